// File: rtl/tx_arb_pkg.sv
// Shared definitions for the two-port MAC TX arbiter: word layout, word codes, FSM encoding
// and parameter defaults.
package tx_arb_pkg;

    localparam int unsigned DataW = 134;

    localparam logic [1:0] CodeHead = 2'b01;
    localparam logic [1:0] CodeMid  = 2'b11;
    localparam logic [1:0] CodeTail = 2'b10;

    localparam int unsigned MaxConsecDef = 4;
    localparam int unsigned StartToDef   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StGrant0,
        StGrant1,
        StXfer0,
        StXfer1,
        StGap
    } state_e;

endpackage

// File: rtl/tx_arb_pick.sv
// Port selection for tx_arb: strict priority to port 0, with port 1 forced through after
// MaxConsec back-to-back port-0 grants made while it was waiting.
module tx_arb_pick
    import tx_arb_pkg::*;
#(
    parameter int unsigned MaxConsec = MaxConsecDef
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req0_i,
    input  logic req1_i,
    input  logic grant_i,
    output logic sel1_o
);

    localparam logic [2:0] ConsecMax = 3'(MaxConsec);

    logic [2:0] consec_q, consec_d;

    always_comb begin
        sel1_o   = req1_i && (!req0_i || (consec_q == ConsecMax));
        consec_d = consec_q;
        if (grant_i) begin
            // Only port-0 grants that made port 1 wait count towards starvation.
            if (sel1_o || !req1_i) begin
                consec_d = '0;
            end else begin
                consec_d = consec_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            consec_q <= '0;
        end else begin
            consec_q <= consec_d;
        end
    end

endmodule

// File: rtl/tx_arb.sv
// Two-port packet arbiter merging the PTP TX engine (port 0) and the data path (port 1)
// into one MAC TX stream, with one-cycle registered forwarding and error/packet statistics.
module tx_arb
    import tx_arb_pkg::*;
#(
    parameter int unsigned MAX_CONSEC = MaxConsecDef,
    parameter int unsigned START_TO   = StartToDef
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_req,
    output logic             in0_ready,
    input  logic             in0_data_wr,
    input  logic [DataW-1:0] in0_data,
    input  logic             in0_valid_wr,
    input  logic             in0_valid,
    input  logic             in1_req,
    output logic             in1_ready,
    input  logic             in1_data_wr,
    input  logic [DataW-1:0] in1_data,
    input  logic             in1_valid_wr,
    input  logic             in1_valid,
    output logic             out_data_wr,
    output logic [DataW-1:0] out_data,
    output logic             out_valid_wr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      pkt_cnt0,
    output logic [31:0]      pkt_cnt1,
    output logic [15:0]      err_cnt
);

    localparam int unsigned TmoW    = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam logic [TmoW-1:0] TmoLast = TmoW'(START_TO - 1);

    state_e           state_q, state_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             rdy0_q, rdy0_d, rdy1_q, rdy1_d;
    logic             odwr_q, odwr_d, ovwr_q, ovwr_d, ovld_q, ovld_d;
    logic [DataW-1:0] odata_q, odata_d;
    logic [31:0]      pkt0_q, pkt0_d, pkt1_q, pkt1_d;
    logic [15:0]      err_q, err_d;

    logic             grant, sel1, err_hit;
    logic             gnt1, granted;
    logic             g_dwr, g_vwr, g_vld, o_dwr, o_vwr;
    logic [DataW-1:0] g_data;

    tx_arb_pick #(
        .MaxConsec (MAX_CONSEC)
    ) u_pick (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .req0_i  (in0_req),
        .req1_i  (in1_req),
        .grant_i (grant),
        .sel1_o  (sel1)
    );

    always_comb begin
        gnt1    = (state_q == StGrant1) || (state_q == StXfer1);
        granted = gnt1 || (state_q == StGrant0) || (state_q == StXfer0);
        g_dwr   = gnt1 ? in1_data_wr  : in0_data_wr;
        g_data  = gnt1 ? in1_data     : in0_data;
        g_vwr   = gnt1 ? in1_valid_wr : in0_valid_wr;
        g_vld   = gnt1 ? in1_valid    : in0_valid;
        o_dwr   = gnt1 ? in0_data_wr  : in1_data_wr;
        o_vwr   = gnt1 ? in0_valid_wr : in1_valid_wr;
    end

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        rdy0_d  = 1'b0;
        rdy1_d  = 1'b0;
        odwr_d  = 1'b0;
        odata_d = odata_q;
        ovwr_d  = 1'b0;
        ovld_d  = ovld_q;
        pkt0_d  = pkt0_q;
        pkt1_d  = pkt1_q;
        grant   = 1'b0;
        err_hit = 1'b0;

        case (state_q)
            StIdle: begin
                if (out_ready && (in0_req || in1_req)) begin
                    grant = 1'b1;
                    tmo_d = '0;
                    if (sel1) begin
                        rdy1_d  = 1'b1;
                        state_d = StGrant1;
                    end else begin
                        rdy0_d  = 1'b1;
                        state_d = StGrant0;
                    end
                end
            end
            StGrant0, StGrant1: begin
                if (g_dwr && (g_data[DataW-1:DataW-2] == CodeHead)) begin
                    odwr_d  = 1'b1;
                    odata_d = g_data;
                    state_d = gnt1 ? StXfer1 : StXfer0;
                end else begin
                    // Anything but a head word from the granted source is dropped.
                    if (g_dwr || g_vwr) begin
                        err_hit = 1'b1;
                    end
                    if (tmo_q == TmoLast) begin
                        err_hit = 1'b1;
                        state_d = StIdle;
                    end else begin
                        tmo_d = tmo_q + TmoW'(1);
                    end
                end
            end
            StXfer0, StXfer1: begin
                if (g_dwr) begin
                    odwr_d  = 1'b1;
                    odata_d = g_data;
                    if (g_data[DataW-1:DataW-2] == CodeHead) begin
                        err_hit = 1'b1;
                    end
                end
                if (g_vwr) begin
                    ovwr_d  = 1'b1;
                    ovld_d  = g_vld;
                    state_d = StGap;
                    if (gnt1) begin
                        pkt1_d = pkt1_q + 32'd1;
                    end else begin
                        pkt0_d = pkt0_q + 32'd1;
                    end
                end
            end
            StGap: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (granted) begin
            if (o_dwr || o_vwr) begin
                err_hit = 1'b1;
            end
        end else if (in0_data_wr || in0_valid_wr || in1_data_wr || in1_valid_wr) begin
            err_hit = 1'b1;
        end

        err_d = (err_hit && (err_q != 16'hFFFF)) ? err_q + 16'd1 : err_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            tmo_q   <= '0;
            rdy0_q  <= 1'b0;
            rdy1_q  <= 1'b0;
            odwr_q  <= 1'b0;
            odata_q <= '0;
            ovwr_q  <= 1'b0;
            ovld_q  <= 1'b0;
            pkt0_q  <= '0;
            pkt1_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            rdy0_q  <= rdy0_d;
            rdy1_q  <= rdy1_d;
            odwr_q  <= odwr_d;
            odata_q <= odata_d;
            ovwr_q  <= ovwr_d;
            ovld_q  <= ovld_d;
            pkt0_q  <= pkt0_d;
            pkt1_q  <= pkt1_d;
            err_q   <= err_d;
        end
    end

    assign in0_ready    = rdy0_q;
    assign in1_ready    = rdy1_q;
    assign out_data_wr  = odwr_q;
    assign out_data     = odata_q;
    assign out_valid_wr = ovwr_q;
    assign out_valid    = ovld_q;
    assign pkt_cnt0     = pkt0_q;
    assign pkt_cnt1     = pkt1_q;
    assign err_cnt      = err_q;

endmodule

// File: tb/tb_tx_arb.sv
// Directed bench for tx_arb: table-driven single packet plus hand-written arbitration,
// timeout, rogue-writer, back-pressure and reset sequences.
module tb_tx_arb;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in0_req, in0_ready, in0_data_wr, in0_valid_wr, in0_valid;
    logic         in1_req, in1_ready, in1_data_wr, in1_valid_wr, in1_valid;
    logic [133:0] in0_data, in1_data, out_data;
    logic         out_data_wr, out_valid_wr, out_valid, out_ready;
    logic [31:0]  pkt_cnt0, pkt_cnt1;
    logic [15:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    tx_arb dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in0_req      (in0_req),
        .in0_ready    (in0_ready),
        .in0_data_wr  (in0_data_wr),
        .in0_data     (in0_data),
        .in0_valid_wr (in0_valid_wr),
        .in0_valid    (in0_valid),
        .in1_req      (in1_req),
        .in1_ready    (in1_ready),
        .in1_data_wr  (in1_data_wr),
        .in1_data     (in1_data),
        .in1_valid_wr (in1_valid_wr),
        .in1_valid    (in1_valid),
        .out_data_wr  (out_data_wr),
        .out_data     (out_data),
        .out_valid_wr (out_valid_wr),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .pkt_cnt0     (pkt_cnt0),
        .pkt_cnt1     (pkt_cnt1),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         dwr;
        logic [133:0] data;
        logic         vwr;
        logic         vld;
        logic         exp_dwr;
        logic [133:0] exp_data;
        logic         exp_vwr;
        logic         exp_vld;
    } vec_t;

    vec_t vt[7];

    function automatic logic [133:0] mkw(input logic [1:0] code, input int tag);
        return {code, 4'hF, 128'(tag)};
    endfunction

    task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in0_data_wr = 0; in0_data = '0; in0_valid_wr = 0; in0_valid = 0;
        in1_data_wr = 0; in1_data = '0; in1_valid_wr = 0; in1_valid = 0;
    endtask

    task automatic set_in(input int p, input logic dwr, input logic [133:0] d,
                          input logic vwr, input logic vld);
        clr_in();
        if (p == 0) begin
            in0_data_wr = dwr; in0_data = d; in0_valid_wr = vwr; in0_valid = vld;
        end else begin
            in1_data_wr = dwr; in1_data = d; in1_valid_wr = vwr; in1_valid = vld;
        end
    endtask

    // Steps until a ready pulse appears; port is -1 when the budget runs out.
    task automatic wait_any(input int max, output int port, output int waited);
        port   = -1;
        waited = 0;
        for (int i = 1; i <= max; i++) begin
            step();
            if (in0_ready || in1_ready) begin
                chk("single_grant", {133'd0, in0_ready & in1_ready}, 134'd0);
                port   = in1_ready ? 1 : 0;
                waited = i;
                return;
            end
        end
        chk("grant_timeout", 134'd0, 134'd1);
    endtask

    // Called right after the ready pulse was seen: checks pulse width, sends head..tail with
    // the descriptor on the tail cycle, checks each forwarded word one cycle later.
    task automatic send_pkt(input int p, input int nw, input int base);
        logic [133:0] w;
        step();
        chk("ready_pulse_width", {133'd0, (p == 0) ? in0_ready : in1_ready}, 134'd0);
        for (int i = 0; i < nw; i++) begin
            w = mkw((i == 0) ? 2'b01 : (i == nw - 1) ? 2'b10 : 2'b11, base + i);
            set_in(p, 1'b1, w, (i == nw - 1), 1'b1);
            step();
            chk("pkt_out_wr", {133'd0, out_data_wr}, 134'd1);
            chk("pkt_out_data", out_data, w);
        end
        chk("pkt_out_valid_wr", {133'd0, out_valid_wr}, 134'd1);
        clr_in();
    endtask

    int port, waited, seen;
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [133:0] rw;

    initial begin
        rst_n = 0; out_ready = 0; in0_req = 0; in1_req = 0;
        clr_in();
        repeat (3) step();
        chk("rst_out_wr", {133'd0, out_data_wr}, 134'd0);
        chk("rst_out_data", out_data, 134'd0);
        chk("rst_ready", {132'd0, in0_ready, in1_ready}, 134'd0);
        chk("rst_err", {118'd0, err_cnt}, 134'd0);
        rst_n = 1;
        step();

        // Single PTP packet from the vector table.
        vt[0] = '{1'b1, mkw(2'b01, 10), 1'b0, 1'b0, 1'b1, mkw(2'b01, 10), 1'b0, 1'b0};
        vt[1] = '{1'b1, mkw(2'b11, 11), 1'b0, 1'b0, 1'b1, mkw(2'b11, 11), 1'b0, 1'b0};
        vt[2] = '{1'b1, mkw(2'b11, 12), 1'b0, 1'b0, 1'b1, mkw(2'b11, 12), 1'b0, 1'b0};
        vt[3] = '{1'b1, mkw(2'b11, 13), 1'b0, 1'b0, 1'b1, mkw(2'b11, 13), 1'b0, 1'b0};
        vt[4] = '{1'b1, mkw(2'b10, 14), 1'b0, 1'b0, 1'b1, mkw(2'b10, 14), 1'b0, 1'b0};
        vt[5] = '{1'b0, 134'd0, 1'b1, 1'b1, 1'b0, 134'd0, 1'b1, 1'b1};
        vt[6] = '{1'b0, 134'd0, 1'b0, 1'b0, 1'b0, 134'd0, 1'b0, 1'b0};
        out_ready = 1; in0_req = 1;
        wait_any(4, port, waited);
        chk("t1_port", 134'(port), 134'd0);
        chk("t1_latency", 134'(waited), 134'd1);
        in0_req = 0;
        step();
        chk("t1_ready_width", {133'd0, in0_ready}, 134'd0);
        foreach (vt[i]) begin
            set_in(0, vt[i].dwr, vt[i].data, vt[i].vwr, vt[i].vld);
            step();
            chk($sformatf("t1_dwr[%0d]", i), {133'd0, out_data_wr}, {133'd0, vt[i].exp_dwr});
            if (vt[i].exp_dwr) chk($sformatf("t1_data[%0d]", i), out_data, vt[i].exp_data);
            chk($sformatf("t1_vwr[%0d]", i), {133'd0, out_valid_wr}, {133'd0, vt[i].exp_vwr});
            if (vt[i].exp_vwr) chk($sformatf("t1_vld[%0d]", i), {133'd0, out_valid}, 134'd1);
        end
        clr_in();
        chk("t1_pkt_cnt0", 134'(pkt_cnt0), 134'd1);
        chk("t1_err", 134'(err_cnt), 134'd0);

        // Anti-starvation with both requests held high.
        in0_req = 1; in1_req = 1;
        for (int k = 0; k < 10; k++) begin
            wait_any(8, port, waited);
            if (port < 0) break;
            chk($sformatf("as_grant[%0d]", k), 134'(port), 134'(exp_seq[k]));
            if (k > 0) chk($sformatf("as_gap[%0d]", k), 134'(waited), 134'd2);
            if (k == 9) begin in0_req = 0; in1_req = 0; end
            send_pkt(port, 2, 100 + 10 * k);
        end
        in0_req = 0; in1_req = 0;
        repeat (3) step();
        chk("as_pkt_cnt0", 134'(pkt_cnt0), 134'd9);
        chk("as_pkt_cnt1", 134'(pkt_cnt1), 134'd2);
        chk("as_err", 134'(err_cnt), 134'd0);

        // Start timeout on port 1.
        in1_req = 1;
        wait_any(4, port, waited);
        chk("to_port", 134'(port), 134'd1);
        in1_req = 0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (out_data_wr) seen++;
        end
        chk("to_err_before", 134'(err_cnt), 134'd0);
        step();
        if (out_data_wr) seen++;
        chk("to_err_after", 134'(err_cnt), 134'd1);
        chk("to_no_output", 134'(seen), 134'd0);
        in1_req = 1;
        step();
        chk("to_back_idle", {133'd0, in1_ready}, 134'd1);
        in1_req = 0;
        send_pkt(1, 2, 300);
        repeat (2) step();
        chk("to_pkt_cnt1", 134'(pkt_cnt1), 134'd3);

        // Rogue writer on port 1 during a port-0 transfer.
        in0_req = 1;
        wait_any(4, port, waited);
        chk("rw_port", 134'(port), 134'd0);
        in0_req = 0;
        step();
        for (int i = 0; i < 5; i++) begin
            rw = mkw((i == 0) ? 2'b01 : (i == 4) ? 2'b10 : 2'b11, 400 + i);
            set_in(0, 1'b1, rw, (i == 4), 1'b1);
            if (i == 1 || i == 3) begin
                in1_data_wr = 1;
                in1_data    = mkw(2'b11, 900 + i);
            end
            step();
            chk($sformatf("rw_data[%0d]", i), out_data, rw);
        end
        clr_in();
        step();
        chk("rw_err", 134'(err_cnt), 134'd3);
        chk("rw_pkt_cnt0", 134'(pkt_cnt0), 134'd10);

        // Back-pressure, then reset in the middle of a transfer.
        out_ready = 0; in0_req = 1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (in0_ready) seen++;
        end
        chk("bp_no_grant", 134'(seen), 134'd0);
        out_ready = 1;
        step();
        chk("bp_grant", {133'd0, in0_ready}, 134'd1);
        in0_req = 0;
        step();
        set_in(0, 1'b1, mkw(2'b01, 500), 1'b0, 1'b0);
        step();
        set_in(0, 1'b1, mkw(2'b11, 501), 1'b0, 1'b0);
        step();
        chk("bp_mid_wr", {133'd0, out_data_wr}, 134'd1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_wr", {133'd0, out_data_wr}, 134'd0);
        chk("rst_mid_data", out_data, 134'd0);
        chk("rst_mid_vld", {132'd0, out_valid_wr, out_valid}, 134'd0);
        chk("rst_mid_pkt0", 134'(pkt_cnt0), 134'd0);
        chk("rst_mid_pkt1", 134'(pkt_cnt1), 134'd0);
        chk("rst_mid_err", 134'(err_cnt), 134'd0);
        clr_in();
        step();
        rst_n = 1;
        step();
        chk("rel_quiet", {130'd0, out_data_wr, out_valid_wr, in0_ready, in1_ready}, 134'd0);
        in0_req = 1;
        step();
        chk("rel_grant", {133'd0, in0_ready}, 134'd1);
        in0_req = 0;
        send_pkt(0, 3, 600);
        repeat (2) step();
        chk("rel_pkt_cnt0", 134'(pkt_cnt0), 134'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
